// File: rtl/rice_csr_arbiter.sv
// Round-robin arbiter sharing the CSR bus between REQUESTERS masters, one transaction outstanding.
// Optional watchdog enabled by defining RICE_CSR_ARBITER_TIMEOUT_EN.
module rice_csr_arbiter #(
  parameter int XLEN           = 32,
  parameter int REQUESTERS     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [REQUESTERS-1:0]      i_req_valid,
  output logic [REQUESTERS-1:0]      o_req_ready,
  input  logic [REQUESTERS-1:0]      i_req_write,
  input  logic [REQUESTERS*12-1:0]   i_req_address,
  input  logic [REQUESTERS*XLEN-1:0] i_req_data,
  output logic [REQUESTERS-1:0]      o_resp_valid,
  output logic                       o_resp_error,
  output logic [XLEN-1:0]            o_resp_data,
  output logic                       o_csr_valid,
  input  logic                       i_csr_ready,
  output logic                       o_csr_write,
  output logic [11:0]                o_csr_address,
  output logic [XLEN-1:0]            o_csr_data,
  input  logic                       i_csr_resp_valid,
  input  logic                       i_csr_resp_error,
  input  logic [XLEN-1:0]            i_csr_resp_data
);

  localparam int IDX_W = $clog2(REQUESTERS);

  if (REQUESTERS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("rice_csr_arbiter: REQUESTERS and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_RESPONSE
  } state_t;

  state_t            state, next_state;
  logic [IDX_W-1:0]  last_grant, grant_idx, winner, cand;
  logic              lat_write, sel_write;
  logic [11:0]       lat_addr, sel_addr;
  logic [XLEN-1:0]   lat_data, sel_data;
  logic              accept, resp_fire, timeout_hit;

  // Walk candidates from the farthest to the nearest so the nearest valid one after last_grant wins.
  always_comb begin
    winner    = '0;
    cand      = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int off = REQUESTERS; off >= 1; off--) begin
      cand = IDX_W'((int'(last_grant) + off) % REQUESTERS);
      if (i_req_valid[cand]) winner = cand;
    end
    for (int k = 0; k < REQUESTERS; k++) begin
      if (winner == IDX_W'(k)) begin
        sel_write = i_req_write[k];
        sel_addr  = i_req_address[k*12 +: 12];
        sel_data  = i_req_data[k*XLEN +: XLEN];
      end
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      last_grant <= IDX_W'(REQUESTERS - 1);
      grant_idx  <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        last_grant <= winner;
        grant_idx  <= winner;
        lat_write  <= sel_write;
        lat_addr   <= sel_addr;
        lat_data   <= sel_data;
      end
    end
  end

`ifdef RICE_CSR_ARBITER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                tmo_cnt <= '0;
    else if (accept)          tmo_cnt <= '0;
    else if (state != S_IDLE) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_hit = (state != S_IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every output and next-state is defaulted first so no path infers a latch.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    resp_fire     = 1'b0;
    o_req_ready   = '0;
    o_resp_valid  = '0;
    o_resp_error  = 1'b0;
    o_resp_data   = '0;
    o_csr_valid   = 1'b0;
    o_csr_write   = 1'b0;
    o_csr_address = '0;
    o_csr_data    = '0;
    case (state)
      S_IDLE: begin
        if (|i_req_valid) begin
          accept              = 1'b1;
          o_req_ready[winner] = 1'b1;
          next_state          = S_REQUEST;
        end
      end
      S_REQUEST: begin
        o_csr_valid   = 1'b1;
        o_csr_write   = lat_write;
        o_csr_address = lat_addr;
        o_csr_data    = lat_data;
        if (i_csr_ready) begin
          resp_fire  = i_csr_resp_valid;
          next_state = i_csr_resp_valid ? S_IDLE : S_RESPONSE;
        end
      end
      S_RESPONSE: begin
        if (i_csr_resp_valid) begin
          resp_fire  = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase

    if (resp_fire) begin
      o_resp_valid[grant_idx] = 1'b1;
      o_resp_error            = i_csr_resp_error;
      o_resp_data             = i_csr_resp_data;
    end else if (timeout_hit) begin
      // Watchdog answers on the slave's behalf and withdraws the bus request.
      o_csr_valid             = 1'b0;
      o_csr_write             = 1'b0;
      o_csr_address           = '0;
      o_csr_data              = '0;
      o_resp_valid[grant_idx] = 1'b1;
      o_resp_error            = 1'b1;
      next_state              = S_IDLE;
    end
  end

endmodule
